// File: rtl/spi_host.sv
// SPI mode-0 host: byte stream in, byte stream out, with CS setup/hold/idle timing.
// Optional macro SPI_HOST_LOOPBACK_EN adds a loopback input (MOSI fed back to the sampler).
module spi_host #(
    parameter int CLK_DIV      = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_IDLE_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
`ifdef SPI_HOST_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_e;

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP_CYC - 1);
    localparam logic [7:0] IDLE_M1  = 8'(CS_IDLE_CYC - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       mosi_q, mosi_d;
    logic [7:0] txsh_q, txsh_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic       last_q, last_d;
    logic [7:0] rxb_q, rxb_d;
    logic       rxv_q, rxv_d;
    logic       ready;
    logic       hs;
    logic       miso_s;

`ifdef SPI_HOST_LOOPBACK_EN
    assign miso_s = loopback ? mosi_q : spi_miso;
`else
    assign miso_s = spi_miso;
`endif

    assign ready    = !rst && (state_q == S_IDLE || state_q == S_WAIT);
    assign hs       = tx_valid && ready;
    assign tx_ready = ready;
    assign busy     = !rst && (state_q != S_IDLE);
    assign rx_valid = rxv_q;
    assign rx_byte  = rxb_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            txsh_q  <= '0;
            rxsh_q  <= '0;
            last_q  <= 1'b0;
            rxb_q   <= '0;
            rxv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            txsh_q  <= txsh_d;
            rxsh_q  <= rxsh_d;
            last_q  <= last_d;
            rxb_q   <= rxb_d;
            rxv_q   <= rxv_d;
        end
    end

    // Next-state logic: CS timing, SCLK divider, bit shifting and byte handoff.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        txsh_d  = txsh_q;
        rxsh_d  = rxsh_q;
        last_d  = last_q;
        rxb_d   = rxb_q;
        rxv_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (hs) begin
                    txsh_d  = {tx_byte[6:0], 1'b0};
                    mosi_d  = tx_byte[7];
                    last_d  = tx_last;
                    cs_n_d  = 1'b0;
                    cnt_d   = SETUP_M1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = DIV_M1;
                    bit_d   = 3'd0;
                    sclk_d  = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    cnt_d = DIV_M1;
                    if (!sclk_q) begin
                        // Rising edge: capture MISO in the same cycle.
                        sclk_d = 1'b1;
                        rxsh_d = {rxsh_q[6:0], miso_s};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            bit_d   = 3'd0;
                            rxb_d   = rxsh_q;
                            rxv_d   = 1'b1;
                            mosi_d  = 1'b0;
                            state_d = last_q ? S_HOLD : S_WAIT;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            mosi_d = txsh_q[7];
                            txsh_d = {txsh_q[6:0], 1'b0};
                        end
                    end
                end
            end
            S_WAIT: begin
                sclk_d = 1'b0;
                if (hs) begin
                    txsh_d  = {tx_byte[6:0], 1'b0};
                    mosi_d  = tx_byte[7];
                    last_d  = tx_last;
                    cnt_d   = DIV_M1;
                    bit_d   = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = IDLE_M1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host (CLK_DIV=2, CS_SETUP_CYC=2, CS_IDLE_CYC=4).
// Define SPI_HOST_LOOPBACK_EN to also exercise the loopback path.
module tb_spi_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       busy;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       tie0 = 1'b0;
`ifdef SPI_HOST_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    spi_host #(
        .CLK_DIV(2),
        .CS_SETUP_CYC(2),
        .CS_IDLE_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_valid(tx_valid),
        .tx_byte(tx_byte),
        .tx_last(tx_last),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .busy(busy),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
`ifdef SPI_HOST_LOOPBACK_EN
        ,
        .loopback(loopback)
`endif
    );

    always #5 clk = ~clk;

    // Slave model: shifts sd out MSB first, advancing on SCLK falling edges.
    logic [15:0] sd = 16'h0000;
    logic [3:0]  kbit = 4'd0;
    always @(negedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) kbit <= 4'd0;
        else kbit <= kbit + 4'd1;
    end
    assign spi_miso = (spi_cs_n === 1'b1 || tie0) ? 1'b0 : sd[4'd15 - kbit];

    // Bus monitor, sampled on the falling clk edge.
    int          n_rise = 0;
    int          n_rxv = 0;
    int          n_cslow = 0;
    int          n_hs = 0;
    int          n_csrise = 0;
    int          hi_run = 0;
    int          last_hi_run = 0;
    int          bad_mosi = 0;
    logic [15:0] mosi_cap = 16'h0000;
    logic [7:0]  rx_h0 = 8'h00;
    logic [7:0]  rx_h1 = 8'h00;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;

    always @(negedge clk) begin
        if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
            n_rise = n_rise + 1;
            mosi_cap = {mosi_cap[14:0], spi_mosi};
        end
        if (rx_valid === 1'b1) begin
            n_rxv = n_rxv + 1;
            rx_h1 = rx_h0;
            rx_h0 = rx_byte;
        end
        if (tx_valid && tx_ready === 1'b1) n_hs = n_hs + 1;
        if (spi_cs_n === 1'b0) n_cslow = n_cslow + 1;
        if (spi_cs_n === 1'b1 && prev_cs === 1'b0) n_csrise = n_csrise + 1;
        if (spi_cs_n === 1'b1 && spi_mosi !== 1'b0) bad_mosi = bad_mosi + 1;
        if (spi_cs_n === 1'b1) begin
            hi_run = hi_run + 1;
        end else begin
            if (prev_cs === 1'b1) last_hi_run = hi_run;
            hi_run = 0;
        end
        prev_sclk = spi_sclk;
        prev_cs = spi_cs_n;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk = n_chk + 1;
        n_err = n_err + 1;
        $display("FAIL %s: timeout got 0 expected 1", name);
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) break;
        end
        if (i == 1000) timeout("wait_ready");
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        if (i == 1000) timeout("wait_idle");
    endtask

    // Offer one byte, complete the handshake, then scramble the inputs.
    task automatic send(input logic [7:0] b, input logic l);
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_byte = b;
        tx_last = l;
        wait_ready();
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_byte = ~b;
        tx_last = ~l;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slave;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
        int         exp_cs;
    } vec_t;

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b_rise, b_rxv, b_cs, b_hs, b_csr;

        vt[0] = '{tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'hA5, exp_cs: 36};
        vt[1] = '{tx: 8'h00, slave: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00, exp_cs: 36};
        vt[2] = '{tx: 8'hFF, slave: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF, exp_cs: 36};
        vt[3] = '{tx: 8'h5A, slave: 8'hA5, exp_rx: 8'hA5, exp_mosi: 8'h5A, exp_cs: 36};
        vt[4] = '{tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E, exp_mosi: 8'h81, exp_cs: 36};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", int'(spi_cs_n), 1);
        chk("rst_sclk", int'(spi_sclk), 0);
        chk("rst_mosi", int'(spi_mosi), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_byte", int'(rx_byte), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(tx_ready), 1);

        // Single-byte transactions
        for (int i = 0; i < 5; i++) begin
            sd = {vt[i].slave, 8'h00};
            b_rise = n_rise;
            b_rxv = n_rxv;
            b_cs = n_cslow;
            send(vt[i].tx, 1'b1);
            wait_idle();
            chk("vec_rx_byte", int'(rx_byte), int'(vt[i].exp_rx));
            chk("vec_mosi", int'(mosi_cap[7:0]), int'(vt[i].exp_mosi));
            chk("vec_rx_pulses", n_rxv - b_rxv, 1);
            chk("vec_sclk_rises", n_rise - b_rise, 8);
            chk("vec_cs_low", n_cslow - b_cs, vt[i].exp_cs);
        end

        // Two bytes in one CS window, second offered while first shifts
        sd = 16'hC35A;
        b_rise = n_rise;
        b_rxv = n_rxv;
        b_cs = n_cslow;
        b_hs = n_hs;
        b_csr = n_csrise;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_byte = 8'h01;
        tx_last = 1'b0;
        wait_ready();
        @(posedge clk);
        #1;
        tx_byte = 8'hFF;
        tx_last = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_idle();
        chk("two_rx_first", int'(rx_h1), 8'hC3);
        chk("two_rx_second", int'(rx_h0), 8'h5A);
        chk("two_rx_pulses", n_rxv - b_rxv, 2);
        chk("two_sclk_rises", n_rise - b_rise, 16);
        chk("two_mosi", int'(mosi_cap), 16'h01FF);
        chk("two_cs_low", n_cslow - b_cs, 69);
        chk("two_cs_rises", n_csrise - b_csr, 1);
        chk("two_handshakes", n_hs - b_hs, 2);

        // tx_valid held through SHIFT/HOLD/GAP into the next transaction
        sd = 16'h6600;
        b_rxv = n_rxv;
        b_hs = n_hs;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_byte = 8'h33;
        tx_last = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        tx_byte = 8'hCC;
        wait_ready();
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_idle();
        chk("held_handshakes", n_hs - b_hs, 2);
        chk("held_rx_pulses", n_rxv - b_rxv, 2);
        chk("held_cs_gap", last_hi_run, 5);
        chk("held_mosi", int'(mosi_cap), 16'h33CC);
        chk("held_rx_byte", int'(rx_byte), 8'h66);

        // Reset 10 cycles into SHIFT
        sd = 16'h0000;
        b_rxv = n_rxv;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_byte = 8'hFF;
        tx_last = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", int'(spi_cs_n), 1);
        chk("abort_sclk", int'(spi_sclk), 0);
        chk("abort_mosi", int'(spi_mosi), 0);
        chk("abort_ready", int'(tx_ready), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("abort_no_rx", n_rxv - b_rxv, 0);
        sd = {8'h3C, 8'h00};
        b_rxv = n_rxv;
        send(8'h5A, 1'b1);
        wait_idle();
        chk("after_abort_rx", int'(rx_byte), 8'h3C);
        chk("after_abort_mosi", int'(mosi_cap[7:0]), 8'h5A);
        chk("after_abort_pulses", n_rxv - b_rxv, 1);

`ifdef SPI_HOST_LOOPBACK_EN
        loopback = 1'b1;
        tie0 = 1'b1;
        b_rxv = n_rxv;
        send(8'hC3, 1'b1);
        wait_idle();
        chk("loopback_rx", int'(rx_byte), 8'hC3);
        chk("loopback_pulses", n_rxv - b_rxv, 1);
        loopback = 1'b0;
        tie0 = 1'b0;
`endif

        chk("mosi_low_when_cs_high", bad_mosi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
